nbody_pair_fetch: RTL and testbench
===================================

// Module: nbody_pair_fetch
// PURPOSE
//  Downstream consumer of the 16-bit particle input buffer. Waits for the buffer's FULL, walks all ordered
//  particle pairs (i,j), i!=j, via the buffer's combinational read port (RD_IDX/RD_SEL/DATA).
//  Emits one 6-word pair record per valid/ready handshake to the force pipeline; then pulses CLEAR to recycle the buffer.
// PARAMETERS
//  N         4               particle count; must equal buffer depth, N>=1
//  IDX_BITS  $clog2(N) (min 1)  particle index width
// PORTS
//  CLK_IN     in   1         clock, all state on rising edge
//  RESET_IN   in   1         asynchronous, active-low reset
//  FULL       in   1         buffer holds N particles
//  CLEAR      out  1         buffer flush request
//  RD_IDX     out  IDX_BITS  buffer read index
//  RD_SEL     out  2         buffer word select: 0=X 1=Y 2=Mass
//  RD_DATA    in   16        buffer read data, combinational from RD_IDX/RD_SEL
//  M_VALID    out  1         pair record valid
//  M_READY    in   1         downstream accepts
//  M_XI,M_YI,M_MI  out 16 each  particle i X/Y/Mass
//  M_XJ,M_YJ,M_MJ  out 16 each  particle j X/Y/Mass
//  M_IDX_I,M_IDX_J out IDX_BITS each  pair indices
//  M_LAST_J   out  1         last pair for current i
//  M_LAST     out  1         last pair of frame
//  BUSY       out  1         FSM not IDLE
// BEHAVIOUR
//  Reset (any time, incl. mid-frame): state IDLE. Every output 0; counters i=j=0. No partial record survives.
//  FSM: IDLE -> LOAD_I -> LOAD_J -> EMIT -> {LOAD_J | LOAD_I | DONE} ; DONE -> IDLE.
//  IDLE: leave when FULL==1. N==1 (no pairs): go straight to DONE.
//  LOAD_I: 3 cycles, RD_IDX=i, RD_SEL=0,1,2; RD_DATA registered into XI/YI/MI each edge.
//  LOAD_J: same for j into XJ/YJ/MJ. Particle i is not reloaded while i is unchanged.
//  EMIT: M_VALID=1, all M_* held stable, RD_IDX/RD_SEL frozen until M_VALID&&M_READY.
//    On accept: advance j (skip j==i). If j exhausted: advance i, restart j. If i exhausted: DONE.
//  Order: i ascending, j ascending, j==i skipped. M_LAST_J on max valid j for i. M_LAST on final pair.
//  Latency: FULL sampled high at edge 0 -> M_VALID high in cycle 7. Steady state: 4 cycles/pair (LOAD_J+EMIT)
//    or 7 on i change, with M_READY held high.
//  DONE: CLEAR=1 (registered) held until FULL sampled 0, then IDLE, CLEAR=0. Prevents re-trigger on stale FULL.
//  FULL falling outside IDLE/DONE is ignored. M_READY is ignored outside EMIT.
//  Counters are IDX_BITS wide. Compare against N-1; never rely on natural wrap, so non-power-of-2 N works.
// CONFIGURATION
//  PAIR_SYM_EN defined: emit only j>i (Newton 3rd law; downstream applies +/-F).
//    i runs 0..N-2; j starts at i+1; N(N-1)/2 pairs. M_LAST on (N-2,N-1).
//  Undefined: all N(N-1) ordered pairs as above. M_LAST on (N-1,N-2).
// STRUCTURE
//  nbody_pkg:
//    WORD_W=16
//    SEL_X=2'd0, SEL_Y=2'd1, SEL_M=2'd2
//    typedef enum pair_fsm_t {IDLE,LOAD_I,LOAD_J,EMIT,DONE}
//    typedef struct pair_rec_t (six 16-bit words)
//  Sub-module nbody_pair_idx_gen: i/j counters, self-skip/symmetry start, last_j/last flags.
//    Advanced by a single 'step' strobe. FSM and word registers stay in top.
// TESTING (N=4, buffer model returning particles 0..3 = {1111,2222,3333},{4444,5555,6666},{7777,8888,9999},{AAAA,BBBB,CCCC})
//  1 Reset hold RESET_IN=0 with FULL=1 -> all outputs 0, BUSY=0. Release -> first M_VALID 7 cycles after FULL sampled.
//  2 FULL=1, M_READY=1 -> 12 records (0,1),(0,2),(0,3),(1,0)..(3,2). First record XI=1111 MI=3333 XJ=4444 MJ=6666.
//    M_LAST_J on (0,3),(1,3),(2,3),(3,2). M_LAST only on (3,2).
//  3 Hold M_READY=0 for 5 cycles on (1,2) -> M_* and RD_IDX/RD_SEL unchanged. (1,2) emitted exactly once; next is (1,3).
//  4 After last accept -> CLEAR=1 next cycle, held while model keeps FULL=1 for 3 cycles.
//    FULL drops -> CLEAR=0, BUSY=0, no new M_VALID.
//  5 Assert RESET_IN=0 during LOAD_J of third pair -> outputs 0 asynchronously.
//    Release with FULL=1 -> frame restarts at (0,1).
//  6 PAIR_SYM_EN -> 6 records (0,1),(0,2),(0,3),(1,2),(1,3),(2,3). M_LAST on (2,3). Then CLEAR as in 4.

Source files
------------

// File: rtl/nbody_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nbody_pkg
// Purpose  : Shared definitions for the n-body pair fetch block. Contains the
//            buffer word width, buffer word-select codes, pair-walk FSM
//            states and the six-word pair record type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package nbody_pkg;

    localparam int WORD_W = 16;

    // Buffer word select codes on RD_SEL
    localparam logic [1:0] SEL_X = 2'd0;
    localparam logic [1:0] SEL_Y = 2'd1;
    localparam logic [1:0] SEL_M = 2'd2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_I = 3'd1,
        LOAD_J = 3'd2,
        EMIT   = 3'd3,
        DONE   = 3'd4
    } pair_fsm_t;

    typedef struct packed {
        logic [WORD_W-1:0] xi;
        logic [WORD_W-1:0] yi;
        logic [WORD_W-1:0] mi;
        logic [WORD_W-1:0] xj;
        logic [WORD_W-1:0] yj;
        logic [WORD_W-1:0] mj;
    } pair_rec_t;

endpackage
`default_nettype wire

// File: rtl/nbody_pair_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : nbody_pair_fetch_if
// Purpose  : Valid/ready pair-record bus from the pair fetch block to the
//            force pipeline.
// Signals  : M_VALID/M_READY handshake, M_XI/M_YI/M_MI and M_XJ/M_YJ/M_MJ
//            particle words, M_IDX_I/M_IDX_J indices, M_LAST_J (last j for
//            this i), M_LAST (last pair of the frame).
// Modports : master (pair fetch side), slave (force pipeline side)
// Revision : 1.0 - initial release
// ============================================================================
interface nbody_pair_fetch_if #(
    parameter int IDX_BITS = 2
);
    import nbody_pkg::*;

    logic                M_VALID;
    logic                M_READY;
    logic [WORD_W-1:0]   M_XI;
    logic [WORD_W-1:0]   M_YI;
    logic [WORD_W-1:0]   M_MI;
    logic [WORD_W-1:0]   M_XJ;
    logic [WORD_W-1:0]   M_YJ;
    logic [WORD_W-1:0]   M_MJ;
    logic [IDX_BITS-1:0] M_IDX_I;
    logic [IDX_BITS-1:0] M_IDX_J;
    logic                M_LAST_J;
    logic                M_LAST;

    modport master (
        output M_VALID, M_XI, M_YI, M_MI, M_XJ, M_YJ, M_MJ,
               M_IDX_I, M_IDX_J, M_LAST_J, M_LAST,
        input  M_READY
    );

    modport slave (
        input  M_VALID, M_XI, M_YI, M_MI, M_XJ, M_YJ, M_MJ,
               M_IDX_I, M_IDX_J, M_LAST_J, M_LAST,
        output M_READY
    );

endinterface
`default_nettype wire

// File: rtl/nbody_pair_idx_gen.sv
`default_nettype none
// ============================================================================
// Module   : nbody_pair_idx_gen
// Purpose  : Particle pair index counters for the pair fetch block. Holds the
//            current (i,j), flags the last j of the current i and the last
//            pair of the frame, and presents the pair that the next step
//            will load so the caller can set up its read index early.
//            Macro PAIR_SYM_EN: walk only j>i; otherwise all i!=j.
// Ports    : CLK_IN, RESET_IN (async active-low)
//            i_start  - load the first pair of a frame
//            i_step   - advance to the next pair
//            o_idx_i/o_idx_j   - current pair
//            o_next_i/o_next_j - pair after the current one
//            o_last_j/o_last   - end of row / end of frame flags
// Revision : 1.0 - initial release
// ============================================================================
module nbody_pair_idx_gen #(
    parameter int N        = 4,
    parameter int IDX_BITS = 2
) (
    input  wire logic                CLK_IN,
    input  wire logic                RESET_IN,
    input  wire logic                i_start,
    input  wire logic                i_step,
    output logic [IDX_BITS-1:0]      o_idx_i,
    output logic [IDX_BITS-1:0]      o_idx_j,
    output logic [IDX_BITS-1:0]      o_next_i,
    output logic [IDX_BITS-1:0]      o_next_j,
    output logic                     o_last_j,
    output logic                     o_last
);

    localparam logic [IDX_BITS-1:0] c_one      = IDX_BITS'(1);
    localparam logic [IDX_BITS-1:0] c_last_idx = IDX_BITS'(N - 1);
    localparam logic [IDX_BITS-1:0] c_pen_idx  = IDX_BITS'((N > 1) ? (N - 2) : 0);

    logic [IDX_BITS-1:0] r_i;
    logic [IDX_BITS-1:0] r_j;
    logic [IDX_BITS-1:0] w_inc_j;
    logic [IDX_BITS-1:0] w_max_j;
    logic [IDX_BITS-1:0] w_last_i;
    logic [IDX_BITS-1:0] w_next_i;
    logic [IDX_BITS-1:0] w_next_j;
    logic                w_last_j;

    // Limits are explicit compares against N-1/N-2 so non-power-of-2 N never
    // depends on counter wrap.
    always_comb begin
        w_inc_j = r_j + c_one;
`ifdef PAIR_SYM_EN
        w_max_j  = c_last_idx;
        w_last_i = c_pen_idx;
`else
        if (w_inc_j == r_i) begin
            w_inc_j = w_inc_j + c_one;
        end
        // Row N-1 cannot use j=N-1, so its last j is N-2.
        w_max_j  = (r_i == c_last_idx) ? c_pen_idx : c_last_idx;
        w_last_i = c_last_idx;
`endif
        w_last_j = (r_j == w_max_j);
        if (w_last_j) begin
            w_next_i = r_i + c_one;
`ifdef PAIR_SYM_EN
            w_next_j = w_next_i + c_one;
`else
            // Any row i>=1 starts at j=0.
            w_next_j = '0;
`endif
        end else begin
            w_next_i = r_i;
            w_next_j = w_inc_j;
        end
    end

    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        if (!RESET_IN) begin
            r_i <= '0;
            r_j <= '0;
        end else if (i_start) begin
            // First pair is (0,1) in both walk modes.
            r_i <= '0;
            r_j <= c_one;
        end else if (i_step) begin
            r_i <= w_next_i;
            r_j <= w_next_j;
        end
    end

    assign o_idx_i  = r_i;
    assign o_idx_j  = r_j;
    assign o_next_i = w_next_i;
    assign o_next_j = w_next_j;
    assign o_last_j = w_last_j;
    assign o_last   = w_last_j && (r_i == w_last_i);

endmodule
`default_nettype wire

// File: rtl/nbody_pair_fetch.sv
`default_nettype none
// ============================================================================
// Module   : nbody_pair_fetch
// Purpose  : Consumer of the particle input buffer. On FULL, reads particle
//            words over the combinational buffer read port, walks every
//            particle pair and emits one six-word record per valid/ready
//            handshake, then holds CLEAR until the buffer drops FULL.
//            Macro PAIR_SYM_EN: emit only pairs with j>i.
// Ports    : CLK_IN, RESET_IN (async active-low)
//            FULL in, CLEAR out          - buffer status / flush request
//            RD_IDX, RD_SEL out, RD_DATA in - buffer read port
//            BUSY out                    - walk in progress
//            m_if (master)               - pair record bus
// Revision : 1.0 - initial release
// ============================================================================
module nbody_pair_fetch
    import nbody_pkg::*;
#(
    parameter int N        = 4,
    parameter int IDX_BITS = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic                CLK_IN,
    input  wire logic                RESET_IN,
    input  wire logic                FULL,
    output logic                     CLEAR,
    output logic [IDX_BITS-1:0]      RD_IDX,
    output logic [1:0]               RD_SEL,
    input  wire logic [WORD_W-1:0]   RD_DATA,
    output logic                     BUSY,
    nbody_pair_fetch_if.master       m_if
);

    localparam bit c_no_pairs = (N == 1);

    pair_fsm_t           r_state;
    pair_rec_t           r_rec;
    logic                r_valid;
    logic                r_clear;
    logic [IDX_BITS-1:0] r_rd_idx;
    logic [1:0]          r_rd_sel;
    logic [IDX_BITS-1:0] r_idx_i;
    logic [IDX_BITS-1:0] r_idx_j;
    logic                r_last_j;
    logic                r_last;

    logic [IDX_BITS-1:0] w_i;
    logic [IDX_BITS-1:0] w_j;
    logic [IDX_BITS-1:0] w_next_i;
    logic [IDX_BITS-1:0] w_next_j;
    logic                w_last_j;
    logic                w_last;
    logic                w_start;
    logic                w_step;

    assign w_start = (r_state == IDLE) && FULL;
    // The final pair never steps; the counters are reloaded by the next start.
    assign w_step  = (r_state == EMIT) && m_if.M_READY && !r_last;

    nbody_pair_idx_gen #(
        .N        (N),
        .IDX_BITS (IDX_BITS)
    ) u_idx_gen (
        .CLK_IN   (CLK_IN),
        .RESET_IN (RESET_IN),
        .i_start  (w_start),
        .i_step   (w_step),
        .o_idx_i  (w_i),
        .o_idx_j  (w_j),
        .o_next_i (w_next_i),
        .o_next_j (w_next_j),
        .o_last_j (w_last_j),
        .o_last   (w_last)
    );

    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        if (!RESET_IN) begin
            r_state  <= IDLE;
            r_rec    <= '0;
            r_valid  <= 1'b0;
            r_clear  <= 1'b0;
            r_rd_idx <= '0;
            r_rd_sel <= SEL_X;
            r_idx_i  <= '0;
            r_idx_j  <= '0;
            r_last_j <= 1'b0;
            r_last   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (FULL) begin
                        if (c_no_pairs) begin
                            r_state <= DONE;
                            r_clear <= 1'b1;
                        end else begin
                            // RD_IDX/RD_SEL are set up one cycle ahead so
                            // the word is valid on the first LOAD_I edge.
                            r_state  <= LOAD_I;
                            r_rd_idx <= '0;
                            r_rd_sel <= SEL_X;
                        end
                    end
                end

                LOAD_I: begin
                    case (r_rd_sel)
                        SEL_X:   r_rec.xi <= RD_DATA;
                        SEL_Y:   r_rec.yi <= RD_DATA;
                        default: r_rec.mi <= RD_DATA;
                    endcase
                    if (r_rd_sel == SEL_M) begin
                        r_state  <= LOAD_J;
                        r_rd_idx <= w_j;
                        r_rd_sel <= SEL_X;
                    end else begin
                        r_rd_sel <= r_rd_sel + 2'd1;
                    end
                end

                LOAD_J: begin
                    case (r_rd_sel)
                        SEL_X:   r_rec.xj <= RD_DATA;
                        SEL_Y:   r_rec.yj <= RD_DATA;
                        default: r_rec.mj <= RD_DATA;
                    endcase
                    if (r_rd_sel == SEL_M) begin
                        r_state  <= EMIT;
                        r_valid  <= 1'b1;
                        r_idx_i  <= w_i;
                        r_idx_j  <= w_j;
                        r_last_j <= w_last_j;
                        r_last   <= w_last;
                    end else begin
                        r_rd_sel <= r_rd_sel + 2'd1;
                    end
                end

                EMIT: begin
                    // Everything, including the read port, is frozen until
                    // the record is accepted.
                    if (m_if.M_READY) begin
                        r_valid <= 1'b0;
                        if (r_last) begin
                            r_state <= DONE;
                            r_clear <= 1'b1;
                        end else if (r_last_j) begin
                            r_state  <= LOAD_I;
                            r_rd_idx <= w_next_i;
                            r_rd_sel <= SEL_X;
                        end else begin
                            // Particle i words are still valid; reload j only.
                            r_state  <= LOAD_J;
                            r_rd_idx <= w_next_j;
                            r_rd_sel <= SEL_X;
                        end
                    end
                end

                DONE: begin
                    // Waiting for FULL to fall keeps a stale FULL from
                    // starting a second walk over the same particles.
                    if (!FULL) begin
                        r_state <= IDLE;
                        r_clear <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_clear <= 1'b0;
                end
            endcase
        end
    end

    assign CLEAR         = r_clear;
    assign RD_IDX        = r_rd_idx;
    assign RD_SEL        = r_rd_sel;
    assign BUSY          = (r_state != IDLE);

    assign m_if.M_VALID  = r_valid;
    assign m_if.M_XI     = r_rec.xi;
    assign m_if.M_YI     = r_rec.yi;
    assign m_if.M_MI     = r_rec.mi;
    assign m_if.M_XJ     = r_rec.xj;
    assign m_if.M_YJ     = r_rec.yj;
    assign m_if.M_MJ     = r_rec.mj;
    assign m_if.M_IDX_I  = r_idx_i;
    assign m_if.M_IDX_J  = r_idx_j;
    assign m_if.M_LAST_J = r_last_j;
    assign m_if.M_LAST   = r_last;

endmodule
`default_nettype wire

// File: tb/tb_nbody_pair_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_nbody_pair_fetch
// Purpose  : Self-checking bench for nbody_pair_fetch (N=4). A buffer model
//            answers the read port; a pair list built from the walk rules is
//            the reference for record order, contents, flags and timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nbody_pair_fetch;
    import nbody_pkg::*;

    localparam int N  = 4;
    localparam int IB = 2;

    logic          CLK_IN = 1'b0;
    logic          RESET_IN;
    logic          FULL;
    logic          CLEAR;
    logic          BUSY;
    logic [IB-1:0] RD_IDX;
    logic [1:0]    RD_SEL;
    logic [15:0]   RD_DATA;

    logic [15:0]   mem [N][3];

    int n_tests = 0;
    int n_fail  = 0;

    nbody_pair_fetch_if #(.IDX_BITS(IB)) m_if ();

    nbody_pair_fetch #(
        .N        (N),
        .IDX_BITS (IB)
    ) dut (
        .CLK_IN   (CLK_IN),
        .RESET_IN (RESET_IN),
        .FULL     (FULL),
        .CLEAR    (CLEAR),
        .RD_IDX   (RD_IDX),
        .RD_SEL   (RD_SEL),
        .RD_DATA  (RD_DATA),
        .BUSY     (BUSY),
        .m_if     (m_if)
    );

    always #5 CLK_IN = ~CLK_IN;

    // Particle buffer: combinational read
    always_comb begin
        RD_DATA = 16'h0;
        if (int'(RD_SEL) < 3) RD_DATA = mem[int'(RD_IDX)][int'(RD_SEL)];
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_IN);
        #1;
    endtask

    task automatic load_fixed();
        logic [15:0] base;
        for (int p = 0; p < N; p++)
            for (int w = 0; w < 3; w++) begin
                base = 16'h1111;
                mem[p][w] = 16'(base * (p * 3 + w + 1));
            end
    endtask

    task automatic load_random();
        for (int p = 0; p < N; p++)
            for (int w = 0; w < 3; w++) mem[p][w] = 16'($urandom);
    endtask

    function automatic logic [127:0] snapshot();
        return {22'h0, m_if.M_XI, m_if.M_YI, m_if.M_MI, m_if.M_XJ, m_if.M_YJ, m_if.M_MJ,
                RD_IDX, RD_SEL, m_if.M_IDX_I, m_if.M_IDX_J, m_if.M_LAST_J, m_if.M_LAST};
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_ctrl"}, {CLEAR, BUSY, m_if.M_VALID, RD_IDX, RD_SEL}, '0);
        check({tag, "_wi"}, {m_if.M_XI, m_if.M_YI, m_if.M_MI}, '0);
        check({tag, "_wj"}, {m_if.M_XJ, m_if.M_YJ, m_if.M_MJ}, '0);
        check({tag, "_idx"}, {m_if.M_IDX_I, m_if.M_IDX_J, m_if.M_LAST_J, m_if.M_LAST}, '0);
    endtask

    // One frame. Timing reference: edge 0 samples FULL, cycle 1 follows it,
    // so "M_VALID in cycle 7" means visible after the 6th edge past edge 0.
    task automatic run_frame(input int ready_pct, input bit do_stall,
                             input bit chk_gap, input int abort_after);
        int  ei[$];
        int  ej[$];
        int  cyc = 0, last_rise = 0, prev_i = -1, n_acc = 0;
        bit  prev_valid = 1'b0, stalled = 1'b0, exp_lj, exp_l;
        logic [127:0] snap;

        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
`ifdef PAIR_SYM_EN
                if (j > i) begin ei.push_back(i); ej.push_back(j); end
`else
                if (j != i) begin ei.push_back(i); ej.push_back(j); end
`endif
            end

        FULL = 1'b1;
        m_if.M_READY = 1'b0;
        tick();
        while (ei.size() > 0 && cyc < 600) begin
            if (m_if.M_VALID && !prev_valid) begin
                if (chk_gap)
                    check("valid_gap", 128'(cyc - last_rise),
                          128'((n_acc == 0) ? 6 : ((ei[0] != prev_i) ? 7 : 4)));
                last_rise = cyc;
            end
            prev_valid = m_if.M_VALID;

            if (do_stall && !stalled && m_if.M_VALID && ei[0] == 1 && ej[0] == 2) begin
                m_if.M_READY = 1'b0;
                snap = snapshot();
                for (int k = 0; k < 5; k++) begin
                    tick();
                    cyc++;
                    check("stall_hold", snapshot(), snap);
                    check("stall_valid", 128'(m_if.M_VALID), 128'(1));
                end
                stalled = 1'b1;
            end

            m_if.M_READY = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
            if (m_if.M_VALID && m_if.M_READY) begin
                exp_lj = (ei.size() == 1) || (ei[1] != ei[0]);
                exp_l  = (ei.size() == 1);
                check("rec_idx", {m_if.M_IDX_I, m_if.M_IDX_J}, {IB'(ei[0]), IB'(ej[0])});
                check("rec_wi", {m_if.M_XI, m_if.M_YI, m_if.M_MI},
                      {mem[ei[0]][0], mem[ei[0]][1], mem[ei[0]][2]});
                check("rec_wj", {m_if.M_XJ, m_if.M_YJ, m_if.M_MJ},
                      {mem[ej[0]][0], mem[ej[0]][1], mem[ej[0]][2]});
                check("rec_flags", {m_if.M_LAST_J, m_if.M_LAST}, {exp_lj, exp_l});
                prev_i = ei[0];
                void'(ei.pop_front());
                void'(ej.pop_front());
                n_acc++;
            end
            tick();
            cyc++;

            if (abort_after >= 0 && n_acc == abort_after) begin
                // Third pair shares i with the second, so this is LOAD_J.
                check("abort_busy", {BUSY, RD_IDX}, {1'b1, IB'(ej[0])});
                #2 RESET_IN = 1'b0;
                #1;
                check_quiet("async_rst");
                return;
            end
        end
        check("pairs_left", 128'(ei.size()), 128'(0));

        check("done_state", {CLEAR, BUSY, m_if.M_VALID}, {1'b1, 1'b1, 1'b0});
        for (int k = 0; k < 2; k++) begin
            tick();
            check("clear_hold", {CLEAR, m_if.M_VALID}, {1'b1, 1'b0});
        end
        FULL = 1'b0;
        tick();
        check("clear_drop", {CLEAR, BUSY}, 2'b00);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("no_retrigger", {BUSY, m_if.M_VALID, CLEAR}, 3'b000);
        end
    endtask

    initial begin
        RESET_IN     = 1'b0;
        FULL         = 1'b1;
        m_if.M_READY = 1'b0;
        load_fixed();

        repeat (3) tick();
        check_quiet("reset_hold");
        RESET_IN = 1'b1;

        // Fixed data, always ready: order, contents, flags, latency
        run_frame(100, 1'b0, 1'b1, -1);
        // Backpressure on (1,2)
        run_frame(100, 1'b1, 1'b0, -1);
        // Reset during LOAD_J of the third pair, then restart from (0,1)
        load_random();
        run_frame(60, 1'b0, 1'b0, 2);
        #4 RESET_IN = 1'b1;
        load_fixed();
        run_frame(100, 1'b0, 1'b1, -1);
        // Random data with random backpressure
        for (int f = 0; f < 3; f++) begin
            load_random();
            run_frame(50, 1'b0, 1'b0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
